bcd_timer_n: RTL and testbench

- Parametrised N-digit decimal (BCD) up/down timer with a built-in prescaler. Successor to the fixed 3-digit, 1 Hz, up-only seconds counter chain.
- Adds the following beyond that chain:
  - any digit count;
  - a programmable tick rate;
  - direction control;
  - synchronous preload;
  - wrap or saturate at terminal count;
  - a single synchronous carry chain instead of ripple-clocked stages.
- Sits between the board clock and the hex display decoders in stopwatch/countdown designs.

---
 rtl/bcd_timer_pkg.sv | 46 ++++
 rtl/bcd_timer_n_digit.sv | 33 +++
 rtl/bcd_timer_n.sv | 107 ++++++++++
 tb/tb_bcd_timer_n.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_timer_pkg.sv
// Shared constants and helpers for the N-digit BCD timer.
// Segment codes are active-low, bit order a..g from MSB to LSB.
package bcd_timer_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_MIN = 4'd0;

    localparam logic [0:6] SEG_0     = 7'b0000001;
    localparam logic [0:6] SEG_1     = 7'b1001111;
    localparam logic [0:6] SEG_2     = 7'b0010010;
    localparam logic [0:6] SEG_3     = 7'b0000110;
    localparam logic [0:6] SEG_4     = 7'b1001100;
    localparam logic [0:6] SEG_5     = 7'b0100100;
    localparam logic [0:6] SEG_6     = 7'b0100000;
    localparam logic [0:6] SEG_7     = 7'b0001111;
    localparam logic [0:6] SEG_8     = 7'b0000000;
    localparam logic [0:6] SEG_9     = 7'b0000100;
    localparam logic [0:6] SEG_BLANK = 7'b1111111;

    // Bits needed to hold 0..value-1; never less than one bit.
    function automatic int clogb2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) w++;
        return w;
    endfunction

    function automatic logic [0:6] seg_encode(input logic [3:0] d);
        logic [0:6] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bcd_timer_n_digit.sv
// One BCD digit of the timer: preload with clamp, up/down step gated
// by the incoming carry, and a combinational carry/borrow output.
module bcd_digit_cell
    import bcd_timer_pkg::*;
(
    input  logic       clk,
    input  logic       aclr,
    input  logic       step,
    input  logic       up,
    input  logic       carry_in,
    input  logic       load,
    input  logic [3:0] load_digit,
    output logic [3:0] digit,
    output logic       carry_out
);

    assign carry_out = carry_in & (up ? (digit == BCD_MAX) : (digit == BCD_MIN));

    // Out-of-range values are folded back to 9 so a digit can never exceed it.
    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            digit <= BCD_MIN;
        end else if (load) begin
            digit <= (load_digit > BCD_MAX) ? BCD_MAX : load_digit;
        end else if (step && carry_in) begin
            if (up)
                digit <= (digit >= BCD_MAX) ? BCD_MIN : digit + 4'd1;
            else
                digit <= (digit == BCD_MIN || digit > BCD_MAX) ? BCD_MAX : digit - 4'd1;
        end
    end

endmodule

// File: rtl/bcd_timer_n.sv
// N-digit BCD up/down timer with prescaler, wrap/saturate terminal handling
// and optional registered 7-segment outputs (enabled by BCD_TIMER_SEG_EN).
module bcd_timer_n
    import bcd_timer_pkg::*;
#(
    parameter int DIGITS   = 3,
    parameter int CLK_HZ   = 50000000,
    parameter int TICK_HZ  = 1,
    parameter int SATURATE = 0
) (
    input  logic                  clk,
    input  logic                  aclr,
    input  logic                  run,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  tick,
    output logic                  term,
    output logic                  at_limit
`ifdef BCD_TIMER_SEG_EN
    ,
    output logic [7*DIGITS-1:0]   seg
`endif
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = clogb2(DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

    logic [PW-1:0]   presc;
    logic            wrap;
    logic            blocked;
    logic            step;
    logic            sat_hit;
    logic [DIGITS:0] carry;

    assign wrap     = run && (presc == PRE_LAST);
    assign carry[0] = 1'b1;
    // The carry chain out of the top digit is exactly "every digit at its limit".
    assign at_limit = carry[DIGITS];
    assign blocked  = (SATURATE != 0) && at_limit;
    assign step     = wrap && !load && !blocked;

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr)
            presc <= '0;
        else if (load)
            presc <= '0;
        else if (run)
            presc <= wrap ? '0 : presc + 1'b1;
    end

    // sat_hit remembers that the current stay at the limit already produced term.
    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            tick    <= 1'b0;
            term    <= 1'b0;
            sat_hit <= 1'b0;
        end else if (load) begin
            tick    <= 1'b0;
            term    <= 1'b0;
            sat_hit <= 1'b0;
        end else begin
            tick <= wrap;
            term <= 1'b0;
            if (wrap) begin
                if (at_limit) begin
                    if (SATURATE != 0) begin
                        term    <= !sat_hit;
                        sat_hit <= 1'b1;
                    end else begin
                        term <= 1'b1;
                    end
                end else begin
                    sat_hit <= 1'b0;
                end
            end
        end
    end

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit_cell u_cell (
            .clk        (clk),
            .aclr       (aclr),
            .step       (step),
            .up         (up),
            .carry_in   (carry[i]),
            .load       (load),
            .load_digit (load_val[4*i +: 4]),
            .digit      (bcd[4*i +: 4]),
            .carry_out  (carry[i+1])
        );
    end

`ifdef BCD_TIMER_SEG_EN
    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            seg <= {DIGITS{SEG_0}};
        end else begin
            for (int i = 0; i < DIGITS; i++)
                seg[7*i +: 7] <= seg_encode(bcd[4*i +: 4]);
        end
    end
`endif

endmodule

// File: tb/tb_bcd_timer_n.sv
// Bench for bcd_timer_n: a wrapping DIV=10 instance and a saturating DIV=3
// instance share stimulus and are compared every cycle to an integer model.
module tb_bcd_timer_n;

    logic        clk;
    logic        aclr;
    logic        run;
    logic        up;
    logic        load;
    logic [11:0] load_val;

    logic [11:0] bcd_w, bcd_s;
    logic        tick_w, tick_s, term_w, term_s, lim_w, lim_s;
`ifdef BCD_TIMER_SEG_EN
    logic [20:0] seg_w, seg_s;
    logic [20:0] m_seg;
    logic [20:0] m_seg_next;
    logic [6:0]  seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                  7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                  7'b0000000, 7'b0000100};
`endif

    int n_checks = 0;
    int n_errors = 0;

    localparam int MAXV = 999;
    int m_div [2] = '{10, 3};
    bit m_sat [2] = '{1'b0, 1'b1};
    int m_cnt [2];
    int m_pre [2];
    bit m_tick [2];
    bit m_term [2];
    bit m_hit [2];

    bcd_timer_n #(.DIGITS(3), .CLK_HZ(10), .TICK_HZ(1), .SATURATE(0)) dut_w (
        .clk(clk), .aclr(aclr), .run(run), .up(up), .load(load), .load_val(load_val),
        .bcd(bcd_w), .tick(tick_w), .term(term_w), .at_limit(lim_w)
`ifdef BCD_TIMER_SEG_EN
        , .seg(seg_w)
`endif
    );

    bcd_timer_n #(.DIGITS(3), .CLK_HZ(3), .TICK_HZ(1), .SATURATE(1)) dut_s (
        .clk(clk), .aclr(aclr), .run(run), .up(up), .load(load), .load_val(load_val),
        .bcd(bcd_s), .tick(tick_s), .term(term_s), .at_limit(lim_s)
`ifdef BCD_TIMER_SEG_EN
        , .seg(seg_s)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        logic [11:0] r;
        int t;
        t = v;
        for (int i = 0; i < 3; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int from_load(input logic [11:0] lv);
        int v, mul, d;
        v = 0;
        mul = 1;
        for (int i = 0; i < 3; i++) begin
            d = int'(lv[4*i +: 4]);
            if (d > 9) d = 9;
            v += d * mul;
            mul *= 10;
        end
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_pre[k] = 0; m_tick[k] = 0; m_term[k] = 0; m_hit[k] = 0;
        end
`ifdef BCD_TIMER_SEG_EN
        m_seg = {3{7'b0000001}};
`endif
    endtask

    // One clock edge of the timer described as integer arithmetic on the count.
    task automatic model_step(input int k);
        bit at_lim;
        m_term[k] = 0;
        m_tick[k] = 0;
        if (load) begin
            m_cnt[k] = from_load(load_val);
            m_pre[k] = 0;
            m_hit[k] = 0;
        end else if (run) begin
            if (m_pre[k] == m_div[k] - 1) begin
                m_pre[k]  = 0;
                m_tick[k] = 1;
                at_lim = up ? (m_cnt[k] == MAXV) : (m_cnt[k] == 0);
                if (at_lim && m_sat[k]) begin
                    m_term[k] = !m_hit[k];
                    m_hit[k]  = 1;
                end else begin
                    m_term[k] = at_lim;
                    m_hit[k]  = 0;
                    m_cnt[k]  = up ? (m_cnt[k] + 1) % (MAXV + 1)
                                   : (m_cnt[k] + MAXV) % (MAXV + 1);
                end
            end else begin
                m_pre[k]++;
            end
        end
    endtask

    task automatic compare_all();
        check_output("w.bcd",  32'(bcd_w),  32'(to_bcd(m_cnt[0])));
        check_output("w.tick", 32'(tick_w), 32'(m_tick[0]));
        check_output("w.term", 32'(term_w), 32'(m_term[0]));
        check_output("w.at_limit", 32'(lim_w), 32'(up ? (m_cnt[0] == MAXV) : (m_cnt[0] == 0)));
        check_output("s.bcd",  32'(bcd_s),  32'(to_bcd(m_cnt[1])));
        check_output("s.tick", 32'(tick_s), 32'(m_tick[1]));
        check_output("s.term", 32'(term_s), 32'(m_term[1]));
        check_output("s.at_limit", 32'(lim_s), 32'(up ? (m_cnt[1] == MAXV) : (m_cnt[1] == 0)));
`ifdef BCD_TIMER_SEG_EN
        check_output("w.seg", 32'(seg_w), 32'(m_seg));
`endif
    endtask

    task automatic apply_stimulus(input bit r, input bit u, input bit l, input logic [11:0] lv);
        @(negedge clk);
        run = r; up = u; load = l; load_val = lv;
`ifdef BCD_TIMER_SEG_EN
        for (int i = 0; i < 3; i++) begin
            int d;
            d = (m_cnt[0] / (i == 0 ? 1 : (i == 1 ? 10 : 100))) % 10;
            m_seg_next[7*i +: 7] = seg_tab[d];
        end
`endif
        for (int k = 0; k < 2; k++) model_step(k);
        @(posedge clk);
        #1;
`ifdef BCD_TIMER_SEG_EN
        m_seg = m_seg_next;
`endif
        compare_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        aclr = 1'b0;
        load = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        aclr = 1'b1;
    endtask

    initial begin
        bit u;
        aclr = 1'b0; run = 1'b0; up = 1'b0; load = 1'b0; load_val = '0;
        do_reset();

        $display("[TB] up carry and wrap / saturate at 999");
        apply_stimulus(1, 1, 1, 12'h998);
        for (int i = 0; i < 25; i++) apply_stimulus(1, 1, 0, 12'h000);

        $display("[TB] down borrow and saturate at 000, then reverse");
        apply_stimulus(1, 0, 1, 12'h001);
        for (int i = 0; i < 15; i++) apply_stimulus(1, 0, 0, 12'h000);
        for (int i = 0; i < 12; i++) apply_stimulus(1, 1, 0, 12'h000);

        $display("[TB] pause at prescaler value 4");
        apply_stimulus(1, 1, 1, 12'h000);
        for (int i = 0; i < 4; i++)  apply_stimulus(1, 1, 0, 12'h000);
        for (int i = 0; i < 25; i++) apply_stimulus(0, 1, 0, 12'h000);
        for (int i = 0; i < 8; i++)  apply_stimulus(1, 1, 0, 12'h000);

        $display("[TB] load collision with prescaler wrap and clamp");
        apply_stimulus(1, 1, 1, 12'h000);
        for (int i = 0; i < 9; i++) apply_stimulus(1, 1, 0, 12'h000);
        apply_stimulus(1, 1, 1, 12'hF3A);
        for (int i = 0; i < 12; i++) apply_stimulus(1, 0, 0, 12'h000);

        $display("[TB] reset mid-count");
        apply_stimulus(1, 1, 1, 12'h057);
        for (int i = 0; i < 3; i++) apply_stimulus(1, 1, 0, 12'h000);
        do_reset();
        for (int i = 0; i < 12; i++) apply_stimulus(1, 1, 0, 12'h000);

        $display("[TB] randomized run");
        u = 1'b1;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 15) == 0) u = ~u;
            apply_stimulus($urandom_range(0, 7) != 0, u, $urandom_range(0, 31) == 0,
                           12'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
